// File: rtl/iq_demod_accumulator.sv
// iq_demod_accumulator: multiplies ADC samples by NCO cos/sin words and sums them over a window.
// Build option IQ_DEMOD_SAT_EN selects saturating accumulation; the default build wraps.
module iq_demod_accumulator #(
  parameter int ADC_W  = 14,
  parameter int TRIG_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic                    gen_clk,
  input  logic                    rst_active_low,
  input  logic                    start,
  input  logic [15:0]             win_len,
  input  logic signed [ADC_W-1:0] adc_sample,
  input  logic                    adc_valid,
  input  logic [31:0]             sine_value,
  input  logic [31:0]             cosine_value,
  output logic signed [ACC_W-1:0] i_out,
  output logic signed [ACC_W-1:0] q_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int PROD_W = ADC_W + TRIG_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   r_state;
  logic [15:0]              r_win_len;
  logic [15:0]              r_cnt;
  logic                     r_s1_vld, r_s1_last;
  logic                     r_s2_vld, r_s2_last;
  logic                     r_s3_last;
  logic signed [ADC_W-1:0]  r_adc;
  logic signed [TRIG_W-1:0] r_cos, r_sin;
  logic signed [PROD_W-1:0] r_prod_i, r_prod_q;
  logic signed [ACC_W-1:0]  r_acc_i, r_acc_q;

  logic                     w_start_ok;
  logic                     w_accept;
  logic signed [PROD_W-1:0] w_adc_ext, w_cos_ext, w_sin_ext;
  logic                     w_unused_trig;

  assign w_start_ok    = (r_state == IDLE) && start && (win_len != 16'd0);
  assign w_accept      = (r_state == ACCUM) && adc_valid && (r_cnt < r_win_len);
  assign w_adc_ext     = PROD_W'(r_adc);
  assign w_cos_ext     = PROD_W'(r_cos);
  assign w_sin_ext     = PROD_W'(r_sin);
  assign w_unused_trig = ^{sine_value[31-TRIG_W:0], cosine_value[31-TRIG_W:0]};

`ifdef IQ_DEMOD_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit exposes overflow; clamp to the rail in the overflow direction.
  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) return sum[ACC_W] ? ACC_MIN : ACC_MAX;
    return sum[ACC_W-1:0];
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction
`endif

  always_ff @(posedge gen_clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      r_state   <= IDLE;
      r_win_len <= '0;
      r_cnt     <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state   <= ACCUM;
            r_win_len <= win_len;
            r_cnt     <= '0;
            busy      <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_accept) r_cnt <= r_cnt + 16'd1;
          if (r_s3_last) begin
            i_out     <= r_acc_i;
            q_out     <= r_acc_q;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the datapath is reset as well, so a window aborted by reset leaves nothing in flight.
  always_ff @(posedge gen_clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s3_last <= 1'b0;
      r_adc     <= '0;
      r_cos     <= '0;
      r_sin     <= '0;
      r_prod_i  <= '0;
      r_prod_q  <= '0;
      r_acc_i   <= '0;
      r_acc_q   <= '0;
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_last <= w_accept && ((r_cnt + 16'd1) == r_win_len);
      if (w_accept) begin
        r_adc <= adc_sample;
        r_cos <= cosine_value[31 -: TRIG_W];
        r_sin <= sine_value[31 -: TRIG_W];
      end

      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      if (r_s1_vld) begin
        r_prod_i <= w_adc_ext * w_cos_ext;
        r_prod_q <= w_adc_ext * w_sin_ext;
      end

      r_s3_last <= r_s2_last;
      if (w_start_ok) begin
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else if (r_s2_vld) begin
        r_acc_i <= acc_add(r_acc_i, ACC_W'(r_prod_i));
        r_acc_q <= acc_add(r_acc_q, ACC_W'(r_prod_q));
      end
    end
  end

endmodule

// File: tb/tb_iq_demod_accumulator.sv
// Self-checking bench for iq_demod_accumulator: scoreboard of expected I/Q per window plus
// latency, hold, reset and saturation/wrap checks (IQ_DEMOD_SAT_EN selects the expected rail).
module tb_iq_demod_accumulator;

  localparam int ADC_W  = 14;
  localparam int TRIG_W = 16;
  localparam int ACC_W  = 48;

  logic                    gen_clk        = 1'b0;
  logic                    rst_active_low = 1'b0;
  logic                    start          = 1'b0;
  logic [15:0]             win_len        = 16'd0;
  logic signed [ADC_W-1:0] adc_sample     = '0;
  logic                    adc_valid      = 1'b0;
  logic [31:0]             sine_value     = 32'd0;
  logic [31:0]             cosine_value   = 32'd0;
  logic                    out_ready      = 1'b0;
  logic signed [ACC_W-1:0] i_out, q_out;
  logic                    out_valid, busy;
  logic signed [31:0]      i32, q32;
  logic                    v32, b32;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic signed [ACC_W-1:0] i;
    logic signed [ACC_W-1:0] q;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  logic prev_valid = 1'b0;

  iq_demod_accumulator #(.ADC_W(ADC_W), .TRIG_W(TRIG_W), .ACC_W(ACC_W)) dut (
    .gen_clk(gen_clk), .rst_active_low(rst_active_low), .start(start), .win_len(win_len),
    .adc_sample(adc_sample), .adc_valid(adc_valid), .sine_value(sine_value),
    .cosine_value(cosine_value), .i_out(i_out), .q_out(q_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  iq_demod_accumulator #(.ADC_W(ADC_W), .TRIG_W(TRIG_W), .ACC_W(32)) dut32 (
    .gen_clk(gen_clk), .rst_active_low(rst_active_low), .start(start), .win_len(win_len),
    .adc_sample(adc_sample), .adc_valid(adc_valid), .sine_value(sine_value),
    .cosine_value(cosine_value), .i_out(i32), .q_out(q32), .out_valid(v32),
    .out_ready(out_ready), .busy(b32)
  );

  always #5 gen_clk = ~gen_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each new result is compared against the oldest outstanding expectation.
  always @(negedge gen_clk) begin
    if (out_valid && !prev_valid) begin
      check("sb_pending", sb_q.size(), 1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("sb_i_out", i_out, sb_e.i);
        check("sb_q_out", q_out, sb_e.q);
      end
    end
    prev_valid <= out_valid;
  end

  task automatic push_exp(input logic signed [ACC_W-1:0] ei, input logic signed [ACC_W-1:0] eq);
    exp_t e;
    e.i = ei;
    e.q = eq;
    sb_q.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] len);
    start   = 1'b1;
    win_len = len;
    @(posedge gen_clk); #1;
    start   = 1'b0;
  endtask

  task automatic drive_cycle(input logic v, input logic signed [ADC_W-1:0] s,
                             input logic [31:0] c, input logic [31:0] sn);
    adc_valid    = v;
    adc_sample   = s;
    cosine_value = c;
    sine_value   = sn;
    @(posedge gen_clk); #1;
  endtask

  // edges0 = edges already elapsed since the final sample was presented.
  task automatic wait_valid(input string tag, input int edges0, input int exp_edges);
    int e;
    e = edges0;
    adc_valid = 1'b0;
    while (!out_valid && e < 20) begin
      @(posedge gen_clk); #1;
      e++;
    end
    if (exp_edges > 0) check(tag, e, exp_edges);
    else               check(tag, out_valid, 1'b1);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge gen_clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_low"}, out_valid, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic v_pat [5];
    logic signed [31:0] exp32;
    v_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge gen_clk);
    #1;
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_active_low = 1'b1;
    @(posedge gen_clk); #1;

    // Constant sample, full-scale cosine, latency of exactly four edges
    push_exp(48'sd13106800, 48'sd0);
    do_start(16'd4);
    check("t1_busy_rise", busy, 1'b1);
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 14'sd100, 32'h7FFF0000, 32'h0);
    wait_valid("t1_latency", 1, 4);
    check("t1_busy_done", busy, 1'b1);
    release_result("t1");

    // Stalls between samples, trailing valid samples after the window are ignored
    push_exp(48'sd0, -48'sd2457600);
    do_start(16'd3);
    for (int k = 0; k < 5; k++)
      drive_cycle(v_pat[k], v_pat[k] ? -14'sd50 : 14'sd999, 32'h0, 32'h40000000);
    drive_cycle(1'b1, 14'sd1000, 32'h7FFF0000, 32'h7FFF0000);
    drive_cycle(1'b1, 14'sd1000, 32'h7FFF0000, 32'h7FFF0000);
    wait_valid("t2_latency", 3, 4);
    release_result("t2");

    // Result held under back-pressure while start is pulsed
    push_exp(48'sd42, -48'sd14);
    do_start(16'd2);
    for (int k = 0; k < 2; k++) drive_cycle(1'b1, 14'sd7, 32'h00030000, 32'hFFFF0000);
    wait_valid("t3_valid", 1, 0);
    start   = 1'b1;
    win_len = 16'd5;
    for (int k = 0; k < 10; k++) begin
      @(posedge gen_clk); #1;
      check("t3_hold_valid", out_valid, 1'b1);
      check("t3_hold_i", i_out, 48'sd42);
      check("t3_hold_q", q_out, -48'sd14);
    end
    start = 1'b0;
    release_result("t3");
    repeat (3) @(posedge gen_clk);
    #1;
    check("t3_no_queued_start", busy, 1'b0);

    // Reset mid-window, then a fresh single-sample window
    do_start(16'd8);
    for (int k = 0; k < 2; k++) drive_cycle(1'b1, 14'sd300, 32'h7FFF0000, 32'h7FFF0000);
    rst_active_low = 1'b0;
    #1;
    check("t4_rst_i_out", i_out, 0);
    check("t4_rst_q_out", q_out, 0);
    check("t4_rst_valid", out_valid, 1'b0);
    check("t4_rst_busy", busy, 1'b0);
    adc_valid = 1'b0;
    @(posedge gen_clk); #1;
    rst_active_low = 1'b1;
    @(posedge gen_clk); #1;
    push_exp(48'sd1, 48'sd0);
    do_start(16'd1);
    drive_cycle(1'b1, 14'sd1, 32'h00010000, 32'h0);
    wait_valid("t4_latency", 1, 4);
    release_result("t4");

    // Overflow of a 32-bit accumulator: clamps or wraps by build option
`ifdef IQ_DEMOD_SAT_EN
    exp32 = 32'h7FFFFFFF;
`else
    exp32 = 32'h80000000;
`endif
    push_exp(48'sh0000_8000_0000, 48'sd0);
    do_start(16'd8);
    for (int k = 0; k < 8; k++) drive_cycle(1'b1, 14'sh2000, 32'h80000000, 32'h0);
    wait_valid("t5_latency", 1, 4);
    check("t5_acc32_valid", v32, 1'b1);
    check("t5_acc32_i", i32, exp32);
    check("t5_acc32_q", q32, 32'sd0);
    release_result("t5");

    // Zero-length window request is ignored
    start   = 1'b1;
    win_len = 16'd0;
    @(posedge gen_clk); #1;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t6_busy", busy, 1'b0);
      check("t6_valid", out_valid, 1'b0);
      drive_cycle(1'b1, 14'sd5, 32'h7FFF0000, 32'h7FFF0000);
    end
    adc_valid = 1'b0;

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
